ysyx_lsu_sram: RTL

YSYX_LSU_SRAM -- requirements
Module: ysyx_lsu_sram

---
 rtl/ysyx_lsu_sram_pkg.sv | 36 +++
 rtl/ysyx_sram_1rw.sv | 42 ++++
 rtl/ysyx_lsu_sram.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ysyx_lsu_sram_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_lsu_sram_pkg
// Purpose : Holds the shared defaults (LATENCY, DEPTH_LOG2), the request op
//           type and the byte-lane helpers used by the LSU SRAM model.
//           A misaligned access is shifted toward the high lanes, and
//           anything that crosses the word boundary is dropped.
// ----------------------------------------------------------------------------
package ysyx_lsu_sram_pkg;

   localparam int YSYX_LATENCY    = 2;
   localparam int YSYX_DEPTH_LOG2 = 10;

   typedef enum logic {
      OP_LOAD  = 1'b0,
      OP_STORE = 1'b1
   } op_e;

   // Byte enables for a store at byte offset off.
   // The result is 4 bits wide, so a strobe that spills past byte 3 loses
   // the lanes that cross the boundary.
   function automatic logic [3:0] lane_enables(input logic [3:0] strb,
                                               input logic [1:0] off);
      logic [3:0] res;
      res = strb << off;
      return res;
   endfunction

   // Store data moved from right-aligned into its byte lanes.
   function automatic logic [31:0] lane_data(input logic [31:0] data,
                                             input logic [1:0]  off);
      logic [31:0] res;
      res = data << {off, 3'b000};
      return res;
   endfunction

endpackage

// File: rtl/ysyx_sram_1rw.sv
// ----------------------------------------------------------------------------
// ysyx_sram_1rw
// Purpose : Single-port word array with four byte-write enables.
//           Writes are synchronous. Reads are combinational. Contents are
//           never reset.
// Ports   : clk      - clock
//           i_we     - write strobe (commits on the rising edge)
//           i_addr   - word index
//           i_be     - per-byte write enables
//           i_wdata  - lane-aligned write data
//           o_rdata  - word at i_addr (combinational)
// ----------------------------------------------------------------------------
module ysyx_sram_1rw
   import ysyx_lsu_sram_pkg::*;
#(
   parameter int DEPTH_LOG2 = YSYX_DEPTH_LOG2
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [DEPTH_LOG2-1:0] i_addr,
   input  logic [3:0]            i_be,
   input  logic [31:0]           i_wdata,
   output logic [31:0]           o_rdata
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   // One independent byte array per lane.
   // Each lane then has exactly one writer, and no per-bit masking is needed.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_mem [0:DEPTH-1];

      always_ff @(posedge clk) begin
         if (i_we && i_be[gi]) begin
            r_mem[i_addr] <= i_wdata[8*gi +: 8];
         end
      end

      assign o_rdata[8*gi +: 8] = r_mem[i_addr];
   end

endmodule

// File: rtl/ysyx_lsu_sram.sv
// ----------------------------------------------------------------------------
// ysyx_lsu_sram
// Purpose : Fixed-latency SRAM responder for the LSU. It serves one request
//           at a time. A store beats a load when both arrive together.
//           The response comes LATENCY cycles after acceptance. After that,
//           the FSM waits until every valid drops, so a held request is not
//           served twice.
// Ports   : clk, rst_n (asynchronous, active-low)
//           lsu_araddr/lsu_arvalid/lsu_rstrb            - load request
//           lsu_rdata/lsu_rvalid                        - load response
//           lsu_awaddr/lsu_awvalid/lsu_wdata/lsu_wstrb/
//           lsu_wvalid                                  - store request
//           lsu_wready                                  - store completion
// Note    : only DATA_W = 32 is supported.
// ----------------------------------------------------------------------------
module ysyx_lsu_sram
   import ysyx_lsu_sram_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int DEPTH_LOG2 = YSYX_DEPTH_LOG2,
   parameter int LATENCY    = YSYX_LATENCY
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] lsu_araddr,
   input  logic              lsu_arvalid,
   input  logic [7:0]        lsu_rstrb,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic              lsu_rvalid,
   input  logic [ADDR_W-1:0] lsu_awaddr,
   input  logic              lsu_awvalid,
   input  logic [DATA_W-1:0] lsu_wdata,
   input  logic [7:0]        lsu_wstrb,
   input  logic              lsu_wvalid,
   output logic              lsu_wready
);

   localparam int IDX_HI = DEPTH_LOG2 + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BUSY  = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   state_e              r_state, w_state_next;
   logic [3:0]          r_cnt, w_cnt_next;
   op_e                 r_op, w_accept_op;
   logic [IDX_HI:0]     r_addr;
   logic [3:0]          r_wstrb;
   logic [DATA_W-1:0]   r_wdata;
   logic                w_accept;
   logic                w_resp;
   logic                w_store_req;
   logic [1:0]          w_off;
   logic [DEPTH_LOG2-1:0] w_idx;
   logic [31:0]         w_rdata;

   assign w_store_req = lsu_awvalid && lsu_wvalid;

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_accept     = 1'b0;
      w_accept_op  = OP_LOAD;
      w_resp       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_store_req) begin
               w_accept     = 1'b1;
               w_accept_op  = OP_STORE;
               w_cnt_next   = 4'(LATENCY - 1);
               w_state_next = S_BUSY;
            end else if (lsu_arvalid) begin
               w_accept     = 1'b1;
               w_accept_op  = OP_LOAD;
               w_cnt_next   = 4'(LATENCY - 1);
               w_state_next = S_BUSY;
            end
         end
         S_BUSY: begin
            if (r_cnt == 4'd0) begin
               w_resp       = 1'b1;
               w_state_next = S_DRAIN;
            end else begin
               w_cnt_next = r_cnt - 4'd1;
            end
         end
         S_DRAIN: begin
            if (!lsu_arvalid && !lsu_awvalid && !lsu_wvalid) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_op    <= OP_LOAD;
         r_addr  <= '0;
         r_wstrb <= 4'd0;
         r_wdata <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         if (w_accept) begin
            r_op <= w_accept_op;
            if (w_accept_op == OP_STORE) begin
               r_addr  <= lsu_awaddr[IDX_HI:0];
               r_wstrb <= lsu_wstrb[3:0];
               r_wdata <= lsu_wdata;
            end else begin
               r_addr <= lsu_araddr[IDX_HI:0];
            end
         end
      end
   end

   assign w_idx = r_addr[IDX_HI:2];
   assign w_off = r_addr[1:0];

   // The responses are decoded from registered state only.
   // Because of that, an asserted rst_n clears them at once.
   assign lsu_rvalid = w_resp && (r_op == OP_LOAD);
   assign lsu_wready = w_resp && (r_op == OP_STORE);

   // Loads return the whole word above the offset, even when rstrb is
   // narrower. The LSU masks and sign-extends the data itself.
   assign lsu_rdata = lsu_rvalid ? DATA_W'(w_rdata >> {w_off, 3'b000}) : '0;

   ysyx_sram_1rw #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_sram (
      .clk     (clk),
      .i_we    (lsu_wready),
      .i_addr  (w_idx),
      .i_be    (lane_enables(r_wstrb, w_off)),
      .i_wdata (lane_data(r_wdata, w_off)),
      .o_rdata (w_rdata)
   );

   // The load strobe, the upper strobe bits and the address bits above the
   // array all have no effect on the result.
   logic w_unused;
   assign w_unused = ^{lsu_rstrb, lsu_wstrb[7:4],
                       lsu_araddr[ADDR_W-1:IDX_HI+1],
                       lsu_awaddr[ADDR_W-1:IDX_HI+1]};

endmodule
